// File: rtl/draw_overlay_box_if.sv
// VGA pipeline bundle shared by all draw stages.
// Latency: none (signal container only).
// Backpressure: none; the pixel stream advances every clock.
// Fields: hcount/vcount pixel coordinates, hsync/vsync, hblnk/vblnk, rgb 4:4:4.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_overlay_box.sv
// Animated overlay box: fades a solid box in over frames, then blinks a border.
// Latency: 1 clock on every vga field and on overlay_active.
// Backpressure: none; consumes and produces one pixel per clock.
// Ports: clk, rst (async active-high), game_state (3b trigger source),
//        vga_in / vga_out (vga_if stream), overlay_active (pixel was modified).
module draw_overlay_box #(
  parameter int          X_START       = 400,
  parameter int          X_END         = 600,
  parameter int          Y_START       = 200,
  parameter int          Y_END         = 300,
  parameter logic [2:0]  TRIGGER_STATE = 3'b100,
  parameter logic [11:0] BOX_RGB       = 12'h0FF,
  parameter int          BORDER_W      = 4,
  parameter logic [11:0] BORDER_RGB    = 12'hFFF,
  parameter int          FADE_DIV      = 4,
  parameter int          BLINK_HALF    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] game_state,
  vga_if.vga_in      vga_in,
  vga_if.vga_out     vga_out,
  output logic       overlay_active
);

  typedef enum logic [1:0] {HIDDEN, FADE_IN, SHOW} state_t;

  localparam logic [10:0] XS  = 11'(X_START);
  localparam logic [10:0] XE  = 11'(X_END);
  localparam logic [10:0] YS  = 11'(Y_START);
  localparam logic [10:0] YE  = 11'(Y_END);
  localparam logic [10:0] XBS = 11'(X_START + BORDER_W);
  localparam logic [10:0] XBE = 11'(X_END - BORDER_W);
  localparam logic [10:0] YBS = 11'(Y_START + BORDER_W);
  localparam logic [10:0] YBE = 11'(Y_END - BORDER_W);
  // Terminal counts; only used when the matching divider is non-zero.
  localparam logic [15:0] FADE_LAST  = 16'(FADE_DIV - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_HALF - 1);

  state_t      state;
  logic [4:0]  alpha;
  logic [15:0] fade_cnt;
  logic [15:0] blink_cnt;
  logic        blink_on;
  logic        vs_d;

  logic frame_tick;
  logic trig;
  assign frame_tick = vga_in.vsync & ~vs_d;
  assign trig       = (game_state == TRIGGER_STATE);

  // Animation state only moves on the vsync rising edge so a frame is never torn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HIDDEN;
      alpha     <= 5'd0;
      fade_cnt  <= 16'd0;
      blink_cnt <= 16'd0;
      blink_on  <= 1'b0;
      vs_d      <= 1'b0;
    end else begin
      vs_d <= vga_in.vsync;
      if (frame_tick) begin
        case (state)
          HIDDEN: begin
            if (trig) begin
              if (FADE_DIV == 0) begin
                state     <= SHOW;
                alpha     <= 5'd16;
                blink_on  <= 1'b1;
                blink_cnt <= 16'd0;
              end else begin
                state    <= FADE_IN;
                alpha    <= 5'd0;
                fade_cnt <= 16'd0;
              end
            end
          end
          FADE_IN: begin
            if (!trig) begin
              state    <= HIDDEN;
              alpha    <= 5'd0;
              fade_cnt <= 16'd0;
            end else if (fade_cnt == FADE_LAST) begin
              fade_cnt <= 16'd0;
              alpha    <= alpha + 5'd1;
              if (alpha == 5'd15) begin
                state     <= SHOW;
                blink_on  <= 1'b1;
                blink_cnt <= 16'd0;
              end
            end else begin
              fade_cnt <= fade_cnt + 16'd1;
            end
          end
          SHOW: begin
            if (!trig) begin
              state     <= HIDDEN;
              alpha     <= 5'd0;
              blink_on  <= 1'b0;
              blink_cnt <= 16'd0;
            end else if (BLINK_HALF > 0) begin
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= 16'd0;
                blink_on  <= ~blink_on;
              end else begin
                blink_cnt <= blink_cnt + 16'd1;
              end
            end
          end
          default: state <= HIDDEN;
        endcase
      end
    end
  end

  // Per-channel alpha blend; worst case 15*16 = 240 still fits 8 bits.
  function automatic logic [3:0] blend4(input logic [3:0] c_in,
                                        input logic [3:0] c_box,
                                        input logic [4:0] a);
    logic [7:0] s;
    s = {4'b0, c_in} * {3'b0, 5'd16 - a} + {4'b0, c_box} * {3'b0, a};
    return s[7:4];
  endfunction

  logic        blanked;
  logic        in_box;
  logic        in_border;
  logic [11:0] rgb_nxt;
  logic        mod_nxt;

  assign blanked = vga_in.hblnk | vga_in.vblnk;
  assign in_box  = (vga_in.hcount >= XS) && (vga_in.hcount < XE) &&
                   (vga_in.vcount >= YS) && (vga_in.vcount < YE);
  assign in_border = in_box &&
                     ((vga_in.hcount < XBS) || (vga_in.hcount >= XBE) ||
                      (vga_in.vcount < YBS) || (vga_in.vcount >= YBE));

  always_comb begin
    rgb_nxt = vga_in.rgb;
    mod_nxt = 1'b0;
    if ((state == SHOW) && in_border && blink_on && !blanked) begin
      rgb_nxt = BORDER_RGB;
      mod_nxt = 1'b1;
    end else if (in_box && (alpha != 5'd0) && !blanked) begin
      rgb_nxt = {blend4(vga_in.rgb[11:8], BOX_RGB[11:8], alpha),
                 blend4(vga_in.rgb[7:4],  BOX_RGB[7:4],  alpha),
                 blend4(vga_in.rgb[3:0],  BOX_RGB[3:0],  alpha)};
      mod_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_out.hcount <= 11'd0;
      vga_out.vcount <= 11'd0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= 12'd0;
      overlay_active <= 1'b0;
    end else begin
      vga_out.hcount <= vga_in.hcount;
      vga_out.vcount <= vga_in.vcount;
      vga_out.hsync  <= vga_in.hsync;
      vga_out.vsync  <= vga_in.vsync;
      vga_out.hblnk  <= vga_in.hblnk;
      vga_out.vblnk  <= vga_in.vblnk;
      vga_out.rgb    <= rgb_nxt;
      overlay_active <= mod_nxt;
    end
  end

endmodule

// File: tb/tb_draw_overlay_box.sv
// Directed bench for draw_overlay_box (FADE_DIV=1, BLINK_HALF=2).
// Latency: expects every output one clock after its input pixel.
// Backpressure: none.
module tb_draw_overlay_box;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] game_state = 3'd0;
  logic       overlay_active;
  int         errors = 0;
  int         checks = 0;

  vga_if vin();
  vga_if vout();

  draw_overlay_box #(.FADE_DIV(1), .BLINK_HALF(2)) dut (
    .clk(clk), .rst(rst), .game_state(game_state),
    .vga_in(vin), .vga_out(vout), .overlay_active(overlay_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one pixel, clock it, and land 1 time unit after the edge.
  task automatic pix(input int h, input int v, input logic hs, input logic vs,
                     input logic hb, input logic vb, input logic [11:0] c);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hsync  = hs;
    vin.vsync  = vs;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = c;
    @(posedge clk);
    #1;
  endtask

  // Active pixel followed by a check of colour and overlay flag.
  task automatic px(input string tag, input int h, input int v, input logic [11:0] c,
                    input logic [11:0] exp_rgb, input logic exp_act);
    pix(h, v, 1'b0, 1'b0, 1'b0, 1'b0, c);
    chk({tag, ".rgb"}, vout.rgb, exp_rgb);
    chk({tag, ".act"}, {11'd0, overlay_active}, {11'd0, exp_act});
  endtask

  // Blanked line with a vsync rising edge: produces exactly one frame tick.
  task automatic frame();
    pix(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
    pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  initial begin
    // Reset: outputs held at zero while inputs are busy.
    vin.hcount = 11'd500; vin.vcount = 11'd250; vin.hsync = 1'b1; vin.vsync = 1'b1;
    vin.hblnk = 1'b1; vin.vblnk = 1'b1; vin.rgb = 12'hABC;
    @(posedge clk); #1;
    chk("rst.rgb", vout.rgb, 12'h000);
    chk("rst.hcount", {1'b0, vout.hcount}, 12'd0);
    chk("rst.hsync", {11'd0, vout.hsync}, 12'd0);
    chk("rst.act", {11'd0, overlay_active}, 12'd0);
    rst = 1'b0;

    // Pass-through ramp with one-cycle latency and no overlay.
    frame();
    for (int i = 0; i < 6; i++) begin
      pix(480 + i, 240 + i, i[0], 1'b0, i[1], 1'b0, 12'(12'h111 * i));
      chk("ramp.rgb", vout.rgb, 12'(12'h111 * i));
      chk("ramp.hcount", {1'b0, vout.hcount}, 12'(480 + i));
      chk("ramp.vcount", {1'b0, vout.vcount}, 12'(240 + i));
      chk("ramp.hsync", {11'd0, vout.hsync}, {11'd0, i[0]});
      chk("ramp.hblnk", {11'd0, vout.hblnk}, {11'd0, i[1]});
      chk("ramp.act", {11'd0, overlay_active}, 12'd0);
      vin.rgb = 12'hFFF;
      #1;
      chk("ramp.hold", vout.rgb, 12'(12'h111 * i));
    end

    // Trigger pulse that does not span a vsync edge is ignored.
    game_state = 3'b100;
    pix(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
    game_state = 3'd0;
    frame();
    px("pulse", 500, 250, 12'h123, 12'h123, 1'b0);

    // Fade in: entry tick leaves alpha at 0.
    game_state = 3'b100;
    frame();
    px("fade0", 500, 250, 12'h000, 12'h000, 1'b0);
    frames(8);
    px("fade8", 500, 250, 12'h000, 12'h077, 1'b1);
    px("fade8.corner", 400, 200, 12'h000, 12'h077, 1'b1);
    frames(7);
    px("fade15", 500, 250, 12'h000, 12'h0EE, 1'b1);
    frames(1);
    // SHOW, blink on (first of two on-frames).
    px("show.ctr", 500, 250, 12'h000, 12'h0FF, 1'b1);
    px("show.corner", 400, 200, 12'h000, 12'hFFF, 1'b1);
    px("show.inner", 404, 250, 12'h000, 12'h0FF, 1'b1);
    px("show.b403", 403, 250, 12'h123, 12'hFFF, 1'b1);
    px("show.b596", 596, 250, 12'h123, 12'hFFF, 1'b1);
    px("show.i595", 595, 250, 12'h123, 12'h0FF, 1'b1);
    px("edge.599", 599, 299, 12'h123, 12'hFFF, 1'b1);
    px("edge.600", 600, 250, 12'h123, 12'h123, 1'b0);
    px("edge.y300", 500, 300, 12'h123, 12'h123, 1'b0);
    px("edge.399", 399, 250, 12'h123, 12'h123, 1'b0);
    px("edge.y199", 500, 199, 12'h123, 12'h123, 1'b0);
    pix(500, 250, 1'b0, 1'b0, 1'b1, 1'b0, 12'h123);
    chk("hblnk.rgb", vout.rgb, 12'h123);
    chk("hblnk.act", {11'd0, overlay_active}, 12'd0);
    pix(400, 200, 1'b0, 1'b0, 1'b0, 1'b1, 12'h123);
    chk("vblnk.rgb", vout.rgb, 12'h123);

    // Blink half-period of 2 frames.
    frame();
    px("blink1.on", 400, 200, 12'h000, 12'hFFF, 1'b1);
    frame();
    px("blink2.off", 400, 200, 12'h000, 12'h0FF, 1'b1);
    px("blink2.inner", 404, 250, 12'h000, 12'h0FF, 1'b1);
    frame();
    px("blink3.off", 400, 200, 12'h000, 12'h0FF, 1'b1);
    frame();
    px("blink4.on", 400, 200, 12'h000, 12'hFFF, 1'b1);

    // Exit from SHOW.
    game_state = 3'd0;
    frame();
    px("hide", 500, 250, 12'h123, 12'h123, 1'b0);
    px("hide.corner", 400, 200, 12'h123, 12'h123, 1'b0);

    // Drop mid-fade at alpha 5, then re-trigger restarts from 0.
    game_state = 3'b100;
    frame();
    frames(5);
    px("a5.black", 500, 250, 12'h000, 12'h044, 1'b1);
    px("a5.red", 500, 250, 12'hF00, 12'hA44, 1'b1);
    game_state = 3'd0;
    frame();
    px("drop", 500, 250, 12'hF00, 12'hF00, 1'b0);
    game_state = 3'b100;
    frame();
    px("retrig0", 500, 250, 12'hF00, 12'hF00, 1'b0);
    frame();
    px("retrig1", 500, 250, 12'hF00, 12'hE00, 1'b1);

    // Reach SHOW, then asynchronous reset with no clock edge.
    frames(15);
    px("show2", 500, 250, 12'h000, 12'h0FF, 1'b1);
    rst = 1'b1;
    #2;
    chk("arst.rgb", vout.rgb, 12'h000);
    chk("arst.act", {11'd0, overlay_active}, 12'd0);
    chk("arst.hcount", {1'b0, vout.hcount}, 12'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    px("post.rst", 500, 250, 12'h123, 12'h123, 1'b0);
    px("post.rst2", 400, 200, 12'h123, 12'h123, 1'b0);
    frame();
    px("post.tick0", 500, 250, 12'hF00, 12'hF00, 1'b0);
    frame();
    px("post.tick1", 500, 250, 12'hF00, 12'hE00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/draw_overlay_box.md
# draw_overlay_box

Parametrised, animated rectangular overlay stage for the VGA drawing chain. When `game_state` equals a configured trigger value, the block fades a solid box into the picture over several frames. Once fully opaque, the box gains a blinking border. The block sits inline in the `vga_if` pipeline like the other draw stages and adds exactly one clock of latency to every timing and colour signal.

## Interface

Parameters:
- `X_START`, default 400: first box column, inclusive.
- `X_END`, default 600: last box column, exclusive.
- `Y_START`, default 200: first box row, inclusive.
- `Y_END`, default 300: last box row, exclusive.
- `TRIGGER_STATE`, default 3'b100: `game_state` value that enables the overlay.
- `BOX_RGB`, default 12'h0FF: fill colour, 4 bits per channel (R, G, B).
- `BORDER_W`, default 4: border thickness in pixels, measured inward from each edge.
- `BORDER_RGB`, default 12'hFFF: border colour.
- `FADE_DIV`, default 4: frames per alpha step. 0 means the box appears instantly.
- `BLINK_HALF`, default 32: frames per border on/off half-period. 0 means the border is steady on.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input, 1 bit: pixel clock.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `game_state` input, 3 bits: game FSM state.
- `vga_in` (`vga_if.vga_in`): upstream hcount, vcount, hsync, vsync, hblnk, vblnk, rgb.
- `vga_out` (`vga_if.vga_out`): the same fields, registered.
- `overlay_active` output, 1 bit: registered; 1 when this cycle's `vga_out.rgb` was modified by the block.

## Operation

- Frame tick:
  - `vs_d` holds the previous `vga_in.vsync`.
  - `frame_tick = vga_in.vsync & ~vs_d`.
  - All FSM, alpha and blink updates happen only on `frame_tick`, so the box never tears mid-frame.
- FSM states: HIDDEN, FADE_IN, SHOW. Reset state is HIDDEN.
- HIDDEN:
  - alpha = 0, border off.
  - On a tick with `game_state == TRIGGER_STATE`: go to FADE_IN with alpha = 0 and frame counter = 0.
  - If `FADE_DIV == 0`, go directly to SHOW with alpha = 16.
- FADE_IN, on each tick:
  - If `game_state != TRIGGER_STATE`: go to HIDDEN, alpha = 0.
  - Otherwise increment the frame counter. When it reaches `FADE_DIV`, clear it and do alpha += 1.
  - When alpha becomes 16, go to SHOW on the same tick, with `blink_on = 1` and blink counter = 0.
- SHOW, on each tick:
  - If `game_state != TRIGGER_STATE`: go to HIDDEN, alpha = 0, `blink_on = 0`.
  - If `BLINK_HALF > 0`: increment the blink counter. At `BLINK_HALF`, clear it and toggle `blink_on`.
  - If `BLINK_HALF == 0`: `blink_on` stays 1.
- Pixel classification, on `vga_in` coordinates:
  - `in_box`: `X_START <= hcount < X_END` and `Y_START <= vcount < Y_END`.
  - `in_border`: `in_box` and the pixel is within `BORDER_W` pixels of any box edge (hcount < X_START+BORDER_W, or hcount >= X_END-BORDER_W, or the same for vcount).
  - Blanked pixels (`hblnk | vblnk`) are never modified.
- Colour:
  - If state is SHOW, `in_border`, `blink_on` and not blanked: output `BORDER_RGB`.
  - Else if `in_box`, alpha > 0 and not blanked: blend each 4-bit channel as out = (in·(16−alpha) + box·alpha) >> 4. Intermediates are 8 bits wide, the result is truncated to 4 bits, there is no rounding.
  - Otherwise: pass `vga_in.rgb` through.
- At alpha = 16 the blend equals `BOX_RGB` exactly. At alpha = 0 no pixel is modified and `overlay_active` = 0.

## Timing

- Latency: every `vga_out` field and `overlay_active` is registered, 1 cycle after `vga_in`. Timing-signal alignment is preserved.
- Reset values:
  - All `vga_out` fields = 0 and `overlay_active` = 0.
  - State HIDDEN, alpha = 0, counters = 0, `blink_on` = 0, `vs_d` = 0.
- Reset mid-fade or mid-blink: immediate return to HIDDEN. No overlay until the first qualifying tick after `rst` deasserts.
- Tick timing: the new state, alpha and blink values are visible starting with the pixel that immediately follows the vsync rising edge.
- Fade duration: from the tick that enters FADE_IN, the block reaches SHOW 16·`FADE_DIV` ticks later.
- `game_state` is sampled only on ticks. A trigger pulse that does not span a vsync rising edge is ignored.
- Simultaneous events: the exit condition has priority over an alpha step or blink toggle on the same tick.

## Test plan

- Reset, then `game_state` = 0 and a ramp on `vga_in` → `vga_out` equals `vga_in` delayed by 1 cycle; `overlay_active` = 0 throughout.
- `FADE_DIV` = 1, `vga_in.rgb` = 12'h000, trigger asserted:
  - After 8 alpha steps, pixel (500,250) → 12'h077.
  - After 16 steps, pixel (500,250) → 12'h0FF, and the state reaches SHOW on that tick.
- In SHOW with `BLINK_HALF` = 2:
  - Pixel (400,200) → 12'hFFF for 2 frames, then 12'h0FF for 2 frames, repeating.
  - Pixel (404,250) stays 12'h0FF.
- Box edges:
  - (599,299) modified; (600,250) and (500,300) unmodified.
  - A pixel inside the box with `hblnk` = 1 → rgb passes through unchanged.
- `game_state` drops mid-fade at alpha = 5 → at the next tick all box pixels equal input rgb. Re-trigger → fade restarts from alpha = 0.
- `rst` pulsed asynchronously during SHOW → outputs are 0 immediately, with no clock edge needed. After release, the box stays hidden until a vsync rising edge with the trigger asserted.
